icache_refill_ctrl: RTL and testbench

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/my_pkg.sv | 25 ++
 rtl/icache_refill_ctrl_if.sv | 28 ++
 rtl/refill_offset_cnt.sv | 26 ++
 rtl/icache_refill_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/my_pkg.sv
// my_pkg: shared types and line geometry for the icache refill path.
// Holds the refill FSM encoding and the SRAM word-address helper.
package my_pkg;

  localparam int IC_LINE_WORDS = 16;
  localparam int IC_OFFSET_W   = 4;
  localparam int IC_TAG_W      = 4;
  localparam int IC_ADDR_W     = 10;
  localparam int IC_DATA_W     = 32;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_FILL,
    RF_DRAIN,
    RF_COMMIT
  } refill_state_e;

  function automatic logic [IC_ADDR_W-1:0] word_addr(
    input logic [IC_TAG_W-1:0]    tag,
    input logic [IC_OFFSET_W-1:0] off
  );
    return {tag, off, 2'b00};
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: instruction SRAM port.
// master = refill controller, slave = SRAM macro.
interface icache_refill_ctrl_if;
  import my_pkg::*;

  logic                 mem_csb;
  logic                 mem_web;
  logic [IC_ADDR_W-1:0] mem_addr;
  logic [IC_DATA_W-1:0] mem_din;
  logic [IC_DATA_W-1:0] mem_dout;

  modport master (
    output mem_csb,
    output mem_web,
    output mem_addr,
    output mem_din,
    input  mem_dout
  );

  modport slave (
    input  mem_csb,
    input  mem_web,
    input  mem_addr,
    input  mem_din,
    output mem_dout
  );

endinterface

// File: rtl/refill_offset_cnt.sv
// refill_offset_cnt: 4-bit line-offset counter, wraps mod 16.
// Priority: reset/clear, then load, then count enable.
module refill_offset_cnt
  import my_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   clr,
  input  logic                   ld,
  input  logic [IC_OFFSET_W-1:0] ld_val,
  input  logic                   en,
  output logic [IC_OFFSET_W-1:0] cnt
);

  // offset register; natural overflow gives the mod-16 wrap
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: fills one 16-word icache line from SRAM on a miss.
// Define ICACHE_CRIT_WORD_FIRST_EN to start the refill at the missed word.
module icache_refill_ctrl
  import my_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   miss_req,
  input  logic [IC_ADDR_W-1:0]   miss_addr,
  input  logic                   flush,
  input  logic                   load_ctrl,
  input  logic [IC_ADDR_W-1:0]   load_addr,
  input  logic [IC_DATA_W-1:0]   load_data,
  icache_refill_ctrl_if.master   mem,
  output logic                   fill_we,
  output logic [IC_OFFSET_W-1:0] fill_offset,
  output logic [IC_TAG_W-1:0]    fill_tag,
  output logic [IC_DATA_W-1:0]   fill_data,
  output logic                   line_valid,
  output logic                   crit_valid,
  output logic [IC_DATA_W-1:0]   crit_data,
  output logic                   busy,
  output logic                   done
);

  localparam logic [IC_OFFSET_W-1:0] LAST_CNT =
    IC_OFFSET_W'(IC_LINE_WORDS - 1);

  refill_state_e state_q;
  refill_state_e state_d;

  logic [IC_TAG_W-1:0]    tag_q;
  logic [IC_OFFSET_W-1:0] crit_q;
  logic [IC_OFFSET_W-1:0] ret_off_q;
  logic [IC_OFFSET_W-1:0] issue_cnt_q;
  logic [IC_OFFSET_W-1:0] off;
  logic [IC_OFFSET_W-1:0] base;
  logic                   pend_q;

  logic in_idle;
  logic in_fill;
  logic in_drain;
  logic in_commit;
  logic accept;
  logic abort;
  logic issue;
  logic last_issue;
  logic off_clr;

  assign in_idle   = (state_q == RF_IDLE);
  assign in_fill   = (state_q == RF_FILL);
  assign in_drain  = (state_q == RF_DRAIN);
  assign in_commit = (state_q == RF_COMMIT);

  assign accept = in_idle & miss_req & EN
                & ~load_ctrl & ~flush;

  assign abort = flush & (in_fill | in_drain);

  // a flush cycle issues nothing: its data would be dropped anyway
  assign issue = in_fill & EN & ~load_ctrl & ~flush;

  assign last_issue = issue & (issue_cnt_q == LAST_CNT);

  assign off_clr = abort | in_commit;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
  assign base = miss_addr[5:2];
`else
  assign base = '0;
`endif

  refill_offset_cnt u_off (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (off_clr),
    .ld     (accept),
    .ld_val (base),
    .en     (issue),
    .cnt    (off)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RF_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush only matters while a line is in progress
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RF_IDLE: begin
        if (accept) state_d = RF_FILL;
      end
      RF_FILL: begin
        if (flush) begin
          state_d = RF_IDLE;
        end else if (last_issue) begin
          state_d = RF_DRAIN;
        end
      end
      RF_DRAIN: begin
        if (flush) begin
          state_d = RF_IDLE;
        end else begin
          state_d = RF_COMMIT;
        end
      end
      RF_COMMIT: begin
        state_d = RF_IDLE;
      end
      default: begin
        state_d = RF_IDLE;
      end
    endcase
  end

  // miss context, issue counter and one-deep read-return tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_q       <= '0;
      crit_q      <= '0;
      issue_cnt_q <= '0;
      ret_off_q   <= '0;
      pend_q      <= 1'b0;
    end else begin
      if (accept) begin
        tag_q       <= miss_addr[9:6];
        crit_q      <= miss_addr[5:2];
        issue_cnt_q <= '0;
      end else if (issue) begin
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
      if (issue) begin
        ret_off_q <= off;
      end
      pend_q <= issue;
    end
  end

  // SRAM port: program load wins, then refill read, else idle
  always_comb begin
    mem.mem_csb  = 1'b1;
    mem.mem_web  = 1'b1;
    mem.mem_addr = '0;
    mem.mem_din  = '0;
    unique case (1'b1)
      load_ctrl: begin
        mem.mem_csb  = 1'b0;
        mem.mem_web  = 1'b0;
        mem.mem_addr = load_addr;
        mem.mem_din  = load_data;
      end
      issue: begin
        mem.mem_csb  = 1'b0;
        mem.mem_addr = word_addr(tag_q, off);
      end
      default: begin
      end
    endcase
  end

  assign fill_we     = pend_q & ~flush;
  assign fill_offset = ret_off_q;
  assign fill_tag    = tag_q;
  assign fill_data   = fill_we ? mem.mem_dout : '0;

  assign crit_valid  = fill_we & (ret_off_q == crit_q);
  assign crit_data   = crit_valid ? mem.mem_dout : '0;

  assign line_valid  = in_commit;
  assign done        = in_commit;
  assign busy        = ~in_idle;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed vectors for the icache refill controller.
// Cycle k is the k-th clock period after the acceptance edge T.
module tb_icache_refill_ctrl;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        miss_req;
  logic [9:0]  miss_addr;
  logic        flush;
  logic        load_ctrl;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        fill_we;
  logic [3:0]  fill_offset;
  logic [3:0]  fill_tag;
  logic [31:0] fill_data;
  logic        line_valid;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic        busy;
  logic        done;

  icache_refill_ctrl_if mem_if ();

  icache_refill_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .miss_req    (miss_req),
    .miss_addr   (miss_addr),
    .flush       (flush),
    .load_ctrl   (load_ctrl),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .mem         (mem_if.master),
    .fill_we     (fill_we),
    .fill_offset (fill_offset),
    .fill_tag    (fill_tag),
    .fill_data   (fill_data),
    .line_valid  (line_valid),
    .crit_valid  (crit_valid),
    .crit_data   (crit_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 CLK = ~CLK;

  logic [31:0] sram [0:1023];

  always @(posedge CLK) begin
    if (!mem_if.mem_csb) begin
      if (!mem_if.mem_web) begin
        sram[mem_if.mem_addr] <= mem_if.mem_din;
      end else begin
        mem_if.mem_dout <= sram[mem_if.mem_addr];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0] addr;
    int ld_at;
    int ld_len;
    int en_at;
    int en_len;
    int fl_at;
    int n_iss;
    int n_wr;
    int n_ld;
    int commit_k;
    int crit_cwf;
    int crit_ncwf;
  } vec_t;

  vec_t vt [6];

  task automatic run_vec(input vec_t v, input int id);
    int ni = 0;
    int ldw = 0;
    int ld_err = 0;
    int ord_err = 0;
    int dup = 0;
    int derr = 0;
    int pf = 0;
    int crit_k = 0;
    int crit_n = 0;
    int commit_k = 0;
    int done_n = 0;
    logic acc = 1'b0;
    logic [15:0] mask = '0;
    logic [15:0] lo;
    logic [31:0] rot;
    logic [3:0] base;
    logic [3:0] off;
    string tg;
    tg = $sformatf("v%0d", id);
    base = CWF ? v.addr[5:2] : 4'd0;
    @(posedge CLK);
    #1;
    miss_req  = 1'b1;
    miss_addr = v.addr;
    @(posedge CLK);
    for (int k = 1; k <= 30; k++) begin
      #1;
      load_ctrl = (k >= v.ld_at) && (k < v.ld_at + v.ld_len);
      EN = !((k >= v.en_at) && (k < v.en_at + v.en_len));
      flush = (k == v.fl_at);
      if (k == v.fl_at) miss_req = 1'b0;
      if (done_n > 0) miss_req = 1'b0;
      load_addr = 10'h3C0 + 10'(k);
      load_data = 32'hA500_0000 + 32'(k);
      @(negedge CLK);
      if (k == 1) acc = busy;
      if (load_ctrl) begin
        if (mem_if.mem_csb === 1'b0 && mem_if.mem_web === 1'b0 &&
            mem_if.mem_addr === load_addr &&
            mem_if.mem_din === load_data) ldw++;
        else ld_err++;
      end else if (mem_if.mem_csb === 1'b0) begin
        if (mem_if.mem_web !== 1'b1) begin
          ld_err++;
        end else begin
          off = base + 4'(ni);
          if (ni >= 16 ||
              mem_if.mem_addr !== {v.addr[9:6], off, 2'b00}) ord_err++;
          ni++;
        end
      end
      if (fill_we) begin
        if (v.fl_at > 0 && k >= v.fl_at) pf++;
        if (mask[fill_offset]) dup++;
        mask[fill_offset] = 1'b1;
        if (fill_tag !== v.addr[9:6] ||
            fill_data !== sram[{fill_tag, fill_offset, 2'b00}]) derr++;
      end
      if (crit_valid) begin
        crit_n++;
        if (crit_k == 0) crit_k = k;
        if (!fill_we || crit_data !== fill_data ||
            fill_offset !== v.addr[5:2]) derr++;
      end
      if (done) begin
        done_n++;
        commit_k = k;
        if (!line_valid) derr++;
      end
      if (v.fl_at > 0 && k == v.fl_at + 1) begin
        chk({tg, "_flush_idle"}, {63'd0, busy}, 64'd0);
      end
      @(posedge CLK);
    end
    #1;
    flush     = 1'b0;
    load_ctrl = 1'b0;
    EN        = 1'b1;
    miss_req  = 1'b0;
    lo  = (v.n_wr >= 16) ? 16'hFFFF : 16'((1 << v.n_wr) - 1);
    rot = {16'd0, lo} << base;
    chk({tg, "_accept"},   {63'd0, acc}, 64'd1);
    chk({tg, "_order"},    64'(ord_err), 64'd0);
    chk({tg, "_issues"},   64'(ni), 64'(v.n_iss));
    chk({tg, "_loads"},    64'(ldw), 64'(v.n_ld));
    chk({tg, "_ld_err"},   64'(ld_err), 64'd0);
    chk({tg, "_wr_mask"},  64'(mask), 64'(rot[15:0] | rot[31:16]));
    chk({tg, "_dup_wr"},   64'(dup), 64'd0);
    chk({tg, "_data"},     64'(derr), 64'd0);
    chk({tg, "_post_fl"},  64'(pf), 64'd0);
    chk({tg, "_crit_k"},   64'(crit_k),
        64'(CWF ? v.crit_cwf : v.crit_ncwf));
    chk({tg, "_crit_n"},   64'(crit_n), 64'd1);
    chk({tg, "_commit_k"}, 64'(commit_k), 64'(v.commit_k));
    chk({tg, "_done_n"},   64'(done_n), 64'(v.commit_k > 0 ? 1 : 0));
  endtask

  initial begin
    int bsum;
    int dsum;
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_9E37);
    end
    vt[0] = '{10'h0C8, 0, 0, 0, 0, 0, 16, 16, 0, 18, 2, 4};
    vt[1] = '{10'h0C8, 5, 3, 0, 0, 0, 16, 16, 3, 21, 2, 4};
    vt[2] = '{10'h0C8, 0, 0, 0, 0, 8, 7, 6, 0, 0, 2, 4};
    vt[3] = '{10'h154, 0, 0, 0, 0, 0, 16, 16, 0, 18, 2, 7};
    vt[4] = '{10'h2B8, 0, 0, 0, 0, 0, 16, 16, 0, 18, 2, 16};
    vt[5] = '{10'h0C8, 0, 0, 3, 2, 0, 16, 16, 0, 20, 2, 6};

    RST       = 1'b1;
    EN        = 1'b1;
    miss_req  = 1'b0;
    miss_addr = '0;
    flush     = 1'b0;
    load_ctrl = 1'b0;
    load_addr = '0;
    load_data = '0;

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mem_ctl", {52'd0, mem_if.mem_csb, mem_if.mem_web,
        mem_if.mem_addr}, {52'd0, 2'b11, 10'd0});
    chk("rst_mem_din", 64'(mem_if.mem_din), 64'd0);
    chk("rst_flags", {49'd0, busy, fill_we, line_valid, done,
        crit_valid, fill_offset, fill_tag, 2'b00}, 64'd0);
    chk("rst_data", {fill_data, crit_data}, 64'd0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // program load while idle
    load_ctrl = 1'b1;
    load_addr = 10'h3FF;
    load_data = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("ld_ctl", {52'd0, mem_if.mem_csb, mem_if.mem_web,
        mem_if.mem_addr}, {52'd0, 2'b00, 10'h3FF});
    chk("ld_din", 64'(mem_if.mem_din), 64'hDEAD_BEEF);
    @(posedge CLK);
    #1 load_ctrl = 1'b0;
    @(negedge CLK);
    chk("ld_written", 64'(sram[10'h3FF]), 64'hDEAD_BEEF);
    chk("idle_mem", {20'd0, mem_if.mem_csb, mem_if.mem_web,
        mem_if.mem_addr, mem_if.mem_din}, {20'd0, 2'b11, 42'd0});

    // miss and flush together in idle: not accepted
    @(posedge CLK);
    #1;
    miss_req  = 1'b1;
    flush     = 1'b1;
    miss_addr = 10'h0C8;
    @(posedge CLK);
    #1;
    miss_req = 1'b0;
    flush    = 1'b0;
    bsum = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      bsum += int'(busy);
      @(posedge CLK);
    end
    chk("miss_flush_busy", 64'(bsum), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vt[i], i);
    end

    // reset in the middle of a fill
    @(posedge CLK);
    #1;
    miss_req  = 1'b1;
    miss_addr = 10'h0C8;
    @(posedge CLK);
    bsum = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      bsum += int'(busy);
      @(posedge CLK);
    end
    chk("rstmid_busy_before", 64'(bsum), 64'd9);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    miss_req = 1'b0;
    @(negedge CLK);
    chk("rstmid_after", {61'd0, busy, mem_if.mem_csb, fill_we},
        {61'd0, 3'b010});
    dsum = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK);
      dsum += int'(done) + int'(line_valid);
      @(posedge CLK);
    end
    chk("rstmid_no_done", 64'(dsum), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
